// File: rtl/write_through_buffer.sv
// Posted-write buffer between cache controller and DRAM, with store-to-load forwarding for fills.
// Latency: forward hit 1 cycle after lookup; fill = DRAM latency + 1; drain one entry per DRAM handshake.
// Backpressure: wr_ready drops while full (registered count); DRAM held via dram_req until dram_ready.
module write_through_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_done,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    dram_req,
    output logic                    dram_we,
    output logic [ADDR_WIDTH-1:0]   dram_addr,
    output logic [DATA_WIDTH-1:0]   dram_wdata,
    input  logic                    dram_ready,
    input  logic [DATA_WIDTH-1:0]   dram_rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, DRAIN, FILL, FWD} state_t;

    state_t                state_q, state_d;
    entry_t                mem [DEPTH];
    logic [PW-1:0]         head_q, tail_q;
    logic [CW-1:0]         count_q;
    logic                  push, pop;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    assign wr_ready = (count_q != CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign push     = wr_valid && wr_ready;
    assign pop      = (state_q == DRAIN) && dram_ready;

    // Scan oldest to youngest so the last match wins; the in-flight push is youngest of all.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q &&
                mem[head_q + PW'(i)].addr[ADDR_WIDTH-1:2] == rd_addr[ADDR_WIDTH-1:2]) begin
                fwd_hit  = 1'b1;
                fwd_data = mem[head_q + PW'(i)].data;
            end
        end
        if (push && wr_addr[ADDR_WIDTH-1:2] == rd_addr[ADDR_WIDTH-1:2]) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req)
                    state_d = fwd_hit ? FWD : FILL;
                else if (!empty)
                    state_d = DRAIN;
            end
            DRAIN: if (dram_ready) state_d = IDLE;
            FILL:  if (dram_ready) state_d = FWD;
            FWD: begin
                rd_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[tail_q] <= '{addr: wr_addr, data: wr_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rd_data    <= '0;
            dram_req   <= 1'b0;
            dram_we    <= 1'b0;
            dram_addr  <= '0;
            dram_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (push)
                tail_q <= tail_q + 1'b1;
            if (pop)
                head_q <= head_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;

            // DRAM request registers load only from IDLE, so dram_req always drops for a cycle.
            case (state_q)
                IDLE: begin
                    if (rd_req) begin
                        if (fwd_hit) begin
                            rd_data <= fwd_data;
                        end else begin
                            dram_req  <= 1'b1;
                            dram_we   <= 1'b0;
                            dram_addr <= rd_addr;
                        end
                    end else if (!empty) begin
                        dram_req   <= 1'b1;
                        dram_we    <= 1'b1;
                        dram_addr  <= mem[head_q].addr;
                        dram_wdata <= mem[head_q].data;
                    end
                end
                DRAIN: if (dram_ready) dram_req <= 1'b0;
                FILL: begin
                    if (dram_ready) begin
                        dram_req <= 1'b0;
                        rd_data  <= dram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_write_through_buffer.sv
// Directed bench for write_through_buffer with a behavioural DRAM responder.
module tb_write_through_buffer;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_done;
    logic [31:0] rd_data;
    logic        dram_req;
    logic        dram_we;
    logic [31:0] dram_addr;
    logic [31:0] dram_wdata;
    logic        dram_ready;
    logic [31:0] dram_rdata;
    logic [2:0]  count;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    write_through_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
        .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
        .dram_ready(dram_ready), .dram_rdata(dram_rdata),
        .count(count), .empty(empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DRAM model: acts 2 time units after each rising edge, asserts ready after dram_lat request cycles.
    int          dram_lat  = 3;
    bit          dram_hold = 1'b0;
    int          wait_cnt  = 0;
    int          gap_viol  = 0;
    int          fill_seen = 0;
    logic        was_ready;
    logic        log_we[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    initial begin
        dram_ready = 1'b0;
        dram_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            was_ready  = dram_ready;
            if (was_ready && dram_req) gap_viol++;
            dram_ready = 1'b0;
            if (dram_req === 1'b1 && !was_ready) begin
                if (!dram_we) fill_seen++;
                if (!dram_hold) begin
                    wait_cnt++;
                    if (wait_cnt >= dram_lat) begin
                        dram_ready = 1'b1;
                        dram_rdata = {16'hDEAD, dram_addr[15:0]};
                        log_we.push_back(dram_we);
                        log_addr.push_back(dram_addr);
                        log_data.push_back(dram_we ? dram_wdata : dram_rdata);
                        wait_cnt = 0;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    int rd_done_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (rd_done) rd_done_cnt++;
    end

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    // Entered and left just after a falling edge.
    task automatic push(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        while (!wr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL push_timeout addr=%h wr_ready=%b required=1", a, wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic drain_all();
        int n = 0;
        dram_hold = 1'b0;
        dram_lat  = 1;
        while (!(empty && !dram_req) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL drain_timeout count=%0d dram_req=%b required count=0 dram_req=0", count, dram_req);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (wr_ready !== 1'b1)   begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        checks++; if (empty !== 1'b1)      begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (count !== 3'd0)      begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (dram_req !== 1'b0)   begin failures++; $display("FAIL reset_dram_req got=%b exp=0", dram_req); end
        checks++; if (rd_done !== 1'b0)    begin failures++; $display("FAIL reset_rd_done got=%b exp=0", rd_done); end
        checks++; if (rd_data !== 32'h0)   begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if (dram_we !== 1'b0)    begin failures++; $display("FAIL reset_dram_we got=%b exp=0", dram_we); end
        checks++; if (dram_addr !== 32'h0) begin failures++; $display("FAIL reset_dram_addr got=%h exp=0", dram_addr); end
        checks++; if (dram_wdata !== 32'h0) begin failures++; $display("FAIL reset_dram_wdata got=%h exp=0", dram_wdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drain_order();
        int n;
        clear_log();
        dram_hold = 1'b0;
        dram_lat  = 3;
        gap_viol  = 0;
        push(32'h10, 32'hDEAD_DEAD);
        push(32'h14, 32'hBEEF_0014);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL drain_count2 got=%0d exp=2", count); end
        n = 0;
        while (count == 3'd2 && n < 50) begin @(negedge clk); n++; end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL drain_count1 got=%0d exp=1", count); end
        n = 0;
        while (count == 3'd1 && n < 50) begin @(negedge clk); n++; end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL drain_count0 got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
        repeat (2) @(negedge clk);
        checks++;
        if (log_addr.size() !== 2) begin
            failures++; $display("FAIL drain_log_size got=%0d exp=2", log_addr.size());
        end else begin
            checks++;
            if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h10 || log_data[0] !== 32'hDEAD_DEAD) begin
                failures++; $display("FAIL drain_first got=%b/%h/%h exp=1/00000010/deaddead", log_we[0], log_addr[0], log_data[0]);
            end
            checks++;
            if (log_we[1] !== 1'b1 || log_addr[1] !== 32'h14 || log_data[1] !== 32'hBEEF_0014) begin
                failures++; $display("FAIL drain_second got=%b/%h/%h exp=1/00000014/beef0014", log_we[1], log_addr[1], log_data[1]);
            end
        end
        checks++; if (gap_viol !== 0) begin failures++; $display("FAIL drain_req_gap got=%0d exp=0", gap_viol); end
    endtask

    task automatic test_full();
        int n;
        clear_log();
        dram_hold = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        checks++; if (count !== 3'd4)   begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL full_wr_ready got=%b exp=0", wr_ready); end
        wr_valid = 1'b1;
        wr_addr  = 32'h110;
        wr_data  = 32'hA000_0004;
        repeat (3) @(negedge clk);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_held_off count got=%0d exp=4", count); end
        dram_lat  = 1;
        dram_hold = 1'b0;
        n = 0;
        while (!wr_ready && n < 20) begin @(negedge clk); n++; end
        dram_hold = 1'b1;
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got=%b exp=1", wr_ready); end
        @(negedge clk);
        wr_valid = 1'b0;
        checks++; if (count !== 3'd4)      begin failures++; $display("FAIL full_fifth_accepted count got=%0d exp=4", count); end
        checks++; if (log_addr.size() !== 1) begin failures++; $display("FAIL full_one_pop got=%0d exp=1", log_addr.size()); end
        drain_all();
        checks++;
        if (log_addr.size() !== 5) begin
            failures++; $display("FAIL full_log_size got=%0d exp=5", log_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (log_addr[i] !== 32'h100 + 32'(4 * i) || log_data[i] !== 32'hA000_0000 + 32'(i)) begin
                    failures++; $display("FAIL full_order idx=%0d got=%h/%h exp=%h/%h", i, log_addr[i], log_data[i],
                                         32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_forward();
        clear_log();
        dram_hold = 1'b1;
        fill_seen = 0;
        wr_valid = 1'b1; wr_addr = 32'h08; wr_data = 32'h1111_1111;
        @(negedge clk);
        wr_data = 32'h2222_2222; rd_req = 1'b1; rd_addr = 32'h08;
        @(negedge clk);
        checks++; if (rd_done !== 1'b1)         begin failures++; $display("FAIL fwd_bypass_done got=%b exp=1", rd_done); end
        checks++; if (rd_data !== 32'h2222_2222) begin failures++; $display("FAIL fwd_bypass_data got=%h exp=22222222", rd_data); end
        wr_data = 32'h3333_3333; rd_req = 1'b0;
        @(negedge clk);
        checks++; if (rd_done !== 1'b0) begin failures++; $display("FAIL fwd_done_pulse got=%b exp=0", rd_done); end
        wr_valid = 1'b0; rd_req = 1'b1; rd_addr = 32'h0A;
        @(negedge clk);
        checks++; if (rd_done !== 1'b1)         begin failures++; $display("FAIL fwd_entry_done got=%b exp=1", rd_done); end
        checks++; if (rd_data !== 32'h3333_3333) begin failures++; $display("FAIL fwd_youngest_data got=%h exp=33333333", rd_data); end
        rd_req = 1'b0;
        @(negedge clk);
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL fwd_no_coalesce count got=%0d exp=3", count); end
        repeat (3) @(negedge clk);
        checks++; if (fill_seen !== 0) begin failures++; $display("FAIL fwd_no_dram_read got=%0d exp=0", fill_seen); end
        drain_all();
        checks++;
        if (log_data.size() !== 3) begin
            failures++; $display("FAIL fwd_log_size got=%0d exp=3", log_data.size());
        end else begin
            checks++;
            if (log_data[0] !== 32'h1111_1111 || log_data[1] !== 32'h2222_2222 || log_data[2] !== 32'h3333_3333) begin
                failures++; $display("FAIL fwd_drain_order got=%h,%h,%h exp=11111111,22222222,33333333",
                                     log_data[0], log_data[1], log_data[2]);
            end
        end
    endtask

    task automatic test_fill_priority();
        int n;
        clear_log();
        dram_hold = 1'b0;
        dram_lat  = 2;
        push(32'h10, 32'h5555_0010);
        rd_req = 1'b1; rd_addr = 32'h20;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (rd_done) break;
        end
        checks++; if (rd_done !== 1'b1)         begin failures++; $display("FAIL fill_done got=%b exp=1", rd_done); end
        checks++; if (n !== 3)                  begin failures++; $display("FAIL fill_latency got=%0d exp=3", n); end
        checks++; if (rd_data !== 32'hDEAD_0020) begin failures++; $display("FAIL fill_data got=%h exp=dead0020", rd_data); end
        rd_req = 1'b0;
        drain_all();
        checks++;
        if (log_addr.size() !== 2) begin
            failures++; $display("FAIL fill_log_size got=%0d exp=2", log_addr.size());
        end else begin
            checks++;
            if (log_we[0] !== 1'b0 || log_addr[0] !== 32'h20) begin
                failures++; $display("FAIL fill_read_first got=%b/%h exp=0/00000020", log_we[0], log_addr[0]);
            end
            checks++;
            if (log_we[1] !== 1'b1 || log_addr[1] !== 32'h10 || log_data[1] !== 32'h5555_0010) begin
                failures++; $display("FAIL fill_drain_after got=%b/%h/%h exp=1/00000010/55550010", log_we[1], log_addr[1], log_data[1]);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int base;
        clear_log();
        dram_hold = 1'b1;
        push(32'h50, 32'h5050_5050);
        wr_valid = 1'b1; wr_addr = 32'h54; wr_data = 32'h5454_5454;
        rd_req = 1'b1; rd_addr = 32'h60;
        @(negedge clk);
        wr_valid = 1'b0;
        checks++;
        if (dram_req !== 1'b1 || dram_we !== 1'b0 || dram_addr !== 32'h60 || count !== 3'd2) begin
            failures++; $display("FAIL rstfill_setup got=%b/%b/%h/%0d exp=1/0/00000060/2", dram_req, dram_we, dram_addr, count);
        end
        base = rd_done_cnt;
        #1 rst = 1'b1;
        #1;
        checks++; if (dram_req !== 1'b0) begin failures++; $display("FAIL rstfill_dram_req got=%b exp=0", dram_req); end
        checks++; if (count !== 3'd0)    begin failures++; $display("FAIL rstfill_count got=%0d exp=0", count); end
        rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dram_hold = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (rd_done_cnt !== base) begin failures++; $display("FAIL rstfill_no_done got=%0d exp=%0d", rd_done_cnt, base); end
        checks++;
        if (empty !== 1'b1 || dram_req !== 1'b0 || log_addr.size() !== 0) begin
            failures++; $display("FAIL rstfill_discarded got=%b/%b/%0d exp=1/0/0", empty, dram_req, log_addr.size());
        end
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_req = 1'b0; rd_addr = '0;
        @(negedge clk);
        test_reset();
        test_drain_order();
        test_full();
        test_forward();
        test_fill_priority();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
